// File: rtl/tick_pkg.sv
// Shared definitions for the tick generator bank.
//   CNT_W_DEFAULT : default counter/reload width per channel
//   FRAME_RELOAD  : reload for a 60 Hz frame tick from 50 MHz (833332 -> 833333 cycles)
//   SLOW_RELOAD   : reload for a ~5 Hz slow game tick from 50 MHz
//   ch_state_e    : per-channel run state (idle after a one-shot expiry, or running)
//   clog2_min1    : channel-select width, never narrower than one bit
package tick_pkg;

  localparam int CNT_W_DEFAULT = 24;
  localparam logic [23:0] FRAME_RELOAD = 24'h0CB734;
  localparam logic [23:0] SLOW_RELOAD  = 24'h989680;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/tick_generator_bank_if.sv
// Control/status bundle for tick_generator_bank.
//   master : drives per-channel enable/one-shot/restart and the reload write port,
//            receives tick, busy and the per-channel run state (debug view).
//   slave  : the bank itself.
// Handshake: there is none; every control is a level or single-cycle strobe sampled on
// the rising clock edge, and tick is a registered single-cycle pulse.
interface tick_generator_bank_if
  import tick_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int CH_W   = clog2_min1(NUM_CH)
);

  logic [NUM_CH-1:0] ch_enable;
  logic [NUM_CH-1:0] ch_oneshot;
  logic [NUM_CH-1:0] restart;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_data;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] run_dbg;

  modport master (
    output ch_enable, ch_oneshot, restart, wr_en, wr_ch, wr_data,
    input  tick, busy, run_dbg
  );

  modport slave (
    input  ch_enable, ch_oneshot, restart, wr_en, wr_ch, wr_data,
    output tick, busy, run_dbg
  );

endinterface

// File: rtl/tick_channel.sv
// One programmable rate divider channel.
//   clock, reset  : system clock, synchronous active-high reset
//   enable_i      : 1 = count, 0 = freeze counter and suppress tick
//   oneshot_i     : 1 = stop running after the next expiry
//   restart_i     : reload counter and start running (wins over everything else)
//   load_i        : write wr_data_i into the reload register this cycle
//   wr_data_i     : new reload value
//   tick_o        : registered one-cycle pulse, one cycle after the counter sat at zero
//   busy_o        : running and enabled
//   run_o         : run state (debug view)
module tick_channel
  import tick_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEFAULT,
  parameter logic [CNT_W-1:0] RESET_VAL  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_i,
  input  logic             oneshot_i,
  input  logic             restart_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] wr_data_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic             run_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             tick_q, tick_d;
  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] eff_reload;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= RESET_VAL;
      reload_q <= RESET_VAL;
      tick_q   <= 1'b0;
      state_q  <= CH_RUN;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tick_q   <= tick_d;
      state_q  <= state_d;
    end
  end

  // A write landing in the same cycle as a reload is used immediately, so a
  // restart with a coincident write starts from the new value.
  assign eff_reload = load_i ? wr_data_i : reload_q;

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    state_d  = state_q;
    if (load_i) begin
      reload_d = wr_data_i;
    end
    if (restart_i) begin
      cnt_d   = eff_reload;
      state_d = CH_RUN;
    end else if (!enable_i || (state_q == CH_IDLE)) begin
      cnt_d = cnt_q;
    end else if (cnt_q == '0) begin
      // Expiry always reloads, so the counter never wraps below zero.
      tick_d = 1'b1;
      cnt_d  = eff_reload;
      if (oneshot_i) begin
        state_d = CH_IDLE;
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign tick_o = tick_q;
  assign run_o  = (state_q == CH_RUN);
  assign busy_o = enable_i && (state_q == CH_RUN);

endmodule

// File: rtl/tick_generator_bank.sv
// Bank of NUM_CH independent programmable tick generators.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : ch_enable/ch_oneshot/restart per channel, reload write port
//                  (wr_en, wr_ch, wr_data), tick/busy/run_dbg per channel
// Channel i resets to RESET_RELOAD[i*CNT_W +: CNT_W]. wr_ch values >= NUM_CH are
// ignored because no channel decodes them.
module tick_generator_bank
  import tick_pkg::*;
#(
  parameter int                      NUM_CH       = 2,
  parameter int                      CNT_W        = CNT_W_DEFAULT,
  parameter logic [NUM_CH*CNT_W-1:0] RESET_RELOAD = {SLOW_RELOAD, FRAME_RELOAD}
) (
  input  logic                 clock,
  input  logic                 reset,
  tick_generator_bank_if.slave bus
);

  localparam int CH_W = clog2_min1(NUM_CH);

  logic [NUM_CH-1:0] tick_vec;
  logic [NUM_CH-1:0] busy_vec;
  logic [NUM_CH-1:0] run_vec;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(i);
    logic load;

    assign load = bus.wr_en && (bus.wr_ch == IDX);

    tick_channel #(
      .CNT_W     (CNT_W),
      .RESET_VAL (RESET_RELOAD[i*CNT_W +: CNT_W])
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .enable_i  (bus.ch_enable[i]),
      .oneshot_i (bus.ch_oneshot[i]),
      .restart_i (bus.restart[i]),
      .load_i    (load),
      .wr_data_i (bus.wr_data),
      .tick_o    (tick_vec[i]),
      .busy_o    (busy_vec[i]),
      .run_o     (run_vec[i])
    );
  end

  assign bus.tick    = tick_vec;
  assign bus.busy    = busy_vec;
  assign bus.run_dbg = run_vec;

endmodule

// File: tb/tb_tick_generator_bank.sv
// Directed bench for tick_generator_bank with CNT_W=8, NUM_CH=2, reloads ch0=3, ch1=5.
// Cycle numbers count rising edges since reset was released; outputs are sampled
// 1 time unit after each edge.
module tb_tick_generator_bank;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic clock;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_err;

  tick_generator_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  tick_generator_bank #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (CNT_W),
    .RESET_RELOAD ({8'd5, 8'd3})
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.ch_enable  = 2'b11;
    bus.ch_oneshot = 2'b00;
    bus.restart    = 2'b00;
    bus.wr_en      = 1'b0;
    bus.wr_ch      = 1'b0;
    bus.wr_data    = 8'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    reset = 1'b1;

    // 1: reset state, then both channels periodic
    do_reset();
    check_eq("rst_tick", int'(bus.tick), 0);
    check_eq("rst_busy", int'(bus.busy), 3);
    check_eq("rst_run", int'(bus.run_dbg), 3);
    for (int c = 1; c <= 12; c++) begin
      step();
      check_eq($sformatf("t1_tick_c%0d", c), int'(bus.tick),
               ((c % 6 == 0) ? 2 : 0) + ((c % 4 == 0) ? 1 : 0));
    end

    // 2: write ch0 reload=1 while cnt=2; current period stays, then every 2 cycles
    do_reset();
    for (int c = 1; c <= 5; c++) step();
    bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_data = 8'd1;
    step();
    bus.wr_en = 1'b0;
    check_eq("t2_tick_c6", int'(bus.tick[0]), 0);
    for (int c = 7; c <= 14; c++) begin
      step();
      check_eq($sformatf("t2_tick_c%0d", c), int'(bus.tick[0]),
               (c >= 8 && c % 2 == 0) ? 1 : 0);
    end

    // 3: ch1 one-shot restart at edge 3 -> single tick at edge 9, busy falls with it
    do_reset();
    step();
    step();
    bus.ch_oneshot = 2'b10;
    bus.restart    = 2'b10;
    step();
    bus.restart = 2'b00;
    check_eq("t3_tick_c3", int'(bus.tick[1]), 0);
    check_eq("t3_busy_c3", int'(bus.busy[1]), 1);
    for (int c = 4; c <= 20; c++) begin
      step();
      check_eq($sformatf("t3_tick_c%0d", c), int'(bus.tick[1]), (c == 9) ? 1 : 0);
      check_eq($sformatf("t3_busy_c%0d", c), int'(bus.busy[1]), (c < 9) ? 1 : 0);
    end

    // 4: freeze ch0 at cnt=2 for 10 edges, resume -> tick 3 edges later
    do_reset();
    step();
    bus.ch_enable = 2'b10;
    for (int c = 2; c <= 11; c++) begin
      step();
      check_eq($sformatf("t4_frz_tick_c%0d", c), int'(bus.tick[0]), 0);
      check_eq($sformatf("t4_frz_busy_c%0d", c), int'(bus.busy[0]), 0);
    end
    bus.ch_enable = 2'b11;
    for (int c = 12; c <= 14; c++) begin
      step();
      check_eq($sformatf("t4_tick_c%0d", c), int'(bus.tick[0]), (c == 14) ? 1 : 0);
    end

    // 5: restart + write 7 exactly when ch0 cnt==0 -> no tick, then ticks at 12, 20
    do_reset();
    for (int c = 1; c <= 3; c++) step();
    bus.restart = 2'b01;
    bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_data = 8'd7;
    step();
    bus.restart = 2'b00;
    bus.wr_en   = 1'b0;
    check_eq("t5_tick_c4", int'(bus.tick[0]), 0);
    for (int c = 5; c <= 20; c++) begin
      step();
      check_eq($sformatf("t5_tick_c%0d", c), int'(bus.tick[0]),
               (c == 12 || c == 20) ? 1 : 0);
    end

    // 6: reload 0 -> continuous ticks; reset mid-run restores 3/5 behaviour
    do_reset();
    bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_data = 8'd0;
    step();
    bus.wr_en = 1'b0;
    check_eq("t6_tick_c1", int'(bus.tick[0]), 0);
    for (int c = 2; c <= 10; c++) begin
      step();
      check_eq($sformatf("t6_tick_c%0d", c), int'(bus.tick[0]), (c >= 4) ? 1 : 0);
    end
    reset = 1'b1;
    step();
    check_eq("t6_rst_tick", int'(bus.tick), 0);
    check_eq("t6_rst_busy", int'(bus.busy), 3);
    reset = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      step();
      check_eq($sformatf("t6_post_tick_c%0d", c), int'(bus.tick),
               ((c % 6 == 0) ? 2 : 0) + ((c % 4 == 0) ? 1 : 0));
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
